// File: rtl/slave_spi_4post.sv
// slave_spi_4post -- SPI mode-0 responder for the 16-bit board link.
//
// Oversamples the asynchronous CS/SCK/MOSI pins in the CLK domain. Each frame
// shifts in one 16-bit word MSB first and shifts out the reply word that was
// captured from TX_W at frame start.
//
// Ports:
//   CLK, RST        system clock, synchronous active-high reset
//   CS, SCK, MOSI   asynchronous SPI pins from the master (CS active-low)
//   MISO, MISO_OE   serial reply and its board tristate enable
//   TX_W            reply word, captured when CS falls
//   RX_W, RX_VALID  last complete received word, one-cycle update strobe
//   BUSY            frame in progress
//   FRAME_ERR       one-cycle strobe when CS rises before a full word arrives
module slave_spi_4post #(
    parameter int SYNC_STAGES = 2,
    parameter int WORD_W      = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              CS,
    input  logic              SCK,
    input  logic              MOSI,
    output logic              MISO,
    output logic              MISO_OE,
    input  logic [WORD_W-1:0] TX_W,
    output logic [WORD_W-1:0] RX_W,
    output logic              RX_VALID,
    output logic              BUSY,
    output logic              FRAME_ERR
);

    localparam int CNT_W = $clog2(WORD_W + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, WAIT_END} state_t;

    logic [SYNC_STAGES-1:0] cs_sync, sck_sync, mosi_sync;
    logic                   cs_prev, sck_prev;
    // Marks which synchronizer stages hold real pin samples since reset.
    logic [SYNC_STAGES-1:0] vld_pipe;
    // Set once CS has genuinely been seen high; a frame already running when
    // reset lifts must not be mistaken for a fresh CS fall.
    logic                   armed;

    logic cs_s, sck_s, mosi_s;
    logic cs_fall, cs_rise, sck_rise, sck_fall;

    assign cs_s   = cs_sync[SYNC_STAGES-1];
    assign sck_s  = sck_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    assign cs_fall  =  cs_prev  & ~cs_s;
    assign cs_rise  = ~cs_prev  &  cs_s;
    assign sck_rise = ~sck_prev &  sck_s;
    assign sck_fall =  sck_prev & ~sck_s;

    always_ff @(posedge CLK) begin
        if (RST) begin
            cs_sync   <= '1;
            sck_sync  <= '0;
            mosi_sync <= '0;
            cs_prev   <= 1'b1;
            sck_prev  <= 1'b0;
            vld_pipe  <= '0;
            armed     <= 1'b0;
        end else begin
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], CS};
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], SCK};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
            cs_prev   <= cs_s;
            sck_prev  <= sck_s;
            vld_pipe  <= {vld_pipe[SYNC_STAGES-2:0], 1'b1};
            armed     <= armed | (vld_pipe[SYNC_STAGES-1] & cs_s);
        end
    end

    state_t            state;
    // MSB of the reply goes straight to MISO at frame start, so only the
    // remaining bits are held here.
    logic [WORD_W-2:0] tx_sh;
    logic [WORD_W-1:0] rx_sh;
    logic [CNT_W-1:0]  cnt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            tx_sh     <= '0;
            rx_sh     <= '0;
            cnt       <= '0;
            MISO      <= 1'b0;
            MISO_OE   <= 1'b0;
            RX_W      <= '0;
            RX_VALID  <= 1'b0;
            BUSY      <= 1'b0;
            FRAME_ERR <= 1'b0;
        end else begin
            RX_VALID  <= 1'b0;
            FRAME_ERR <= 1'b0;
            case (state)
                IDLE: begin
                    // SCK edges coinciding with the CS fall are dropped here.
                    if (armed && cs_fall) begin
                        tx_sh   <= TX_W[WORD_W-2:0];
                        rx_sh   <= '0;
                        cnt     <= '0;
                        MISO    <= TX_W[WORD_W-1];
                        MISO_OE <= 1'b1;
                        BUSY    <= 1'b1;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (cs_rise) begin
                        MISO    <= 1'b0;
                        MISO_OE <= 1'b0;
                        BUSY    <= 1'b0;
                        state   <= IDLE;
                        // Word completed on the very cycle CS rose: still deliver it.
                        if (cnt == CNT_W'(WORD_W)) begin
                            RX_W     <= rx_sh;
                            RX_VALID <= 1'b1;
                        end else begin
                            FRAME_ERR <= 1'b1;
                        end
                    end else if (cnt == CNT_W'(WORD_W)) begin
                        RX_W     <= rx_sh;
                        RX_VALID <= 1'b1;
                        MISO     <= 1'b0;
                        state    <= WAIT_END;
                    end else if (sck_rise) begin
                        rx_sh <= {rx_sh[WORD_W-2:0], mosi_s};
                        cnt   <= cnt + CNT_W'(1);
                    end else if (sck_fall) begin
                        MISO  <= tx_sh[WORD_W-2];
                        tx_sh <= {tx_sh[WORD_W-3:0], 1'b0};
                    end
                end
                WAIT_END: begin
                    MISO <= 1'b0;
                    if (cs_rise) begin
                        MISO_OE <= 1'b0;
                        BUSY    <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_slave_spi_4post.sv
// Directed bench for slave_spi_4post: a behavioural mode-0 master running
// SCK at f_CLK/8 drives frames; negedge monitors count output strobes.
module tb_slave_spi_4post;

    logic        CLK = 1'b0;
    logic        RST, CS, SCK, MOSI;
    logic        MISO, MISO_OE, RX_VALID, BUSY, FRAME_ERR;
    logic [15:0] TX_W, RX_W;

    int total = 0;
    int bad   = 0;
    int rv_cnt = 0, fe_cnt = 0, busy_cnt = 0;
    int rv0, fe0, busy0;
    logic [15:0] mi;
    logic        extra;

    slave_spi_4post #(.SYNC_STAGES(2), .WORD_W(16)) dut (
        .CLK(CLK), .RST(RST), .CS(CS), .SCK(SCK), .MOSI(MOSI),
        .MISO(MISO), .MISO_OE(MISO_OE), .TX_W(TX_W), .RX_W(RX_W),
        .RX_VALID(RX_VALID), .BUSY(BUSY), .FRAME_ERR(FRAME_ERR)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (RX_VALID === 1'b1)  rv_cnt++;
        if (FRAME_ERR === 1'b1) fe_cnt++;
        if (BUSY === 1'b1)      busy_cnt++;
    end

    task automatic step(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // One SCK cycle: MOSI set, 4 CLK low, rise (master samples MISO), 4 CLK high.
    task automatic sck_cycle(input logic mo_bit, output logic mi_bit);
        MOSI = mo_bit;
        step(4);
        SCK = 1'b1;
        mi_bit = MISO;
        step(4);
        SCK = 1'b0;
    endtask

    // Full master transaction; chg swaps TX_W mid-frame, chk_busy checks BUSY edges.
    task automatic spi_frame(input logic [15:0] mo, input int nclk, input logic chg,
                             input logic [15:0] chg_val, input logic chk_busy,
                             output logic [15:0] mi_w, output logic extra_or);
        logic b;
        mi_w = '0;
        extra_or = 1'b0;
        CS = 1'b0;
        step(2);
        if (chk_busy) chk("busy_before_sync", BUSY, 1'b0);
        step(1);
        if (chk_busy) begin
            chk("busy_after_fall", BUSY, 1'b1);
            chk("oe_after_fall", MISO_OE, 1'b1);
        end
        step(5);
        for (int i = 0; i < nclk; i++) begin
            sck_cycle((i < 16) ? mo[15-i] : 1'b0, b);
            if (i < 16) mi_w[15-i] = b;
            else        extra_or = extra_or | b;
            if (chg && i == 8) TX_W = chg_val;
        end
        step(4);
        CS = 1'b1;
        step(2);
        if (chk_busy) chk("busy_before_rise_sync", BUSY, 1'b1);
        step(1);
        if (chk_busy) begin
            chk("busy_after_rise", BUSY, 1'b0);
            chk("oe_after_rise", MISO_OE, 1'b0);
        end
        step(1);
    endtask

    initial begin
        logic b;
        RST = 1'b1; CS = 1'b1; SCK = 1'b0; MOSI = 1'b0; TX_W = 16'h0000;

        // 1: reset state
        step(3);
        chk("rst_miso", MISO, 1'b0);
        chk("rst_oe", MISO_OE, 1'b0);
        chk("rst_rxw", RX_W, 16'h0000);
        chk("rst_rxv", RX_VALID, 1'b0);
        chk("rst_busy", BUSY, 1'b0);
        chk("rst_ferr", FRAME_ERR, 1'b0);
        RST = 1'b0;
        step(8);

        // 2: full frame
        rv0 = rv_cnt; fe0 = fe_cnt;
        TX_W = 16'h3C5A;
        spi_frame(16'hA5C3, 16, 1'b0, 16'h0, 1'b1, mi, extra);
        chk("f2_miso_word", mi, 16'h3C5A);
        chk("f2_rxw", RX_W, 16'hA5C3);
        chk("f2_rxv_cnt", 16'(rv_cnt - rv0), 16'd1);
        chk("f2_ferr_cnt", 16'(fe_cnt - fe0), 16'd0);

        // 3: good frame, then abort after 8 bits
        TX_W = 16'h0000;
        spi_frame(16'h1234, 16, 1'b0, 16'h0, 1'b0, mi, extra);
        chk("f3_rxw_good", RX_W, 16'h1234);
        rv0 = rv_cnt; fe0 = fe_cnt;
        spi_frame(16'hFFFF, 8, 1'b0, 16'h0, 1'b0, mi, extra);
        chk("f3_ferr_cnt", 16'(fe_cnt - fe0), 16'd1);
        chk("f3_rxv_cnt", 16'(rv_cnt - rv0), 16'd0);
        chk("f3_rxw_held", RX_W, 16'h1234);

        // 4: back-to-back, TX_W changed in the middle of frame 1
        rv0 = rv_cnt;
        TX_W = 16'hA0A0;
        spi_frame(16'h0001, 16, 1'b1, 16'h0F0F, 1'b0, mi, extra);
        chk("f4a_miso_word", mi, 16'hA0A0);
        chk("f4a_rxw", RX_W, 16'h0001);
        spi_frame(16'h8000, 16, 1'b0, 16'h0, 1'b0, mi, extra);
        chk("f4b_miso_word", mi, 16'h0F0F);
        chk("f4b_rxw", RX_W, 16'h8000);
        chk("f4_rxv_cnt", 16'(rv_cnt - rv0), 16'd2);

        // 5: 20 SCK cycles in one frame
        rv0 = rv_cnt; fe0 = fe_cnt;
        TX_W = 16'hFFFF;
        spi_frame(16'hBEEF, 20, 1'b0, 16'h0, 1'b0, mi, extra);
        chk("f5_miso_word", mi, 16'hFFFF);
        chk("f5_miso_extra", extra, 1'b0);
        chk("f5_rxw", RX_W, 16'hBEEF);
        chk("f5_rxv_cnt", 16'(rv_cnt - rv0), 16'd1);
        chk("f5_ferr_cnt", 16'(fe_cnt - fe0), 16'd0);

        // 6: reset after 10 bits, release with CS still low, 6 more SCK
        rv0 = rv_cnt; fe0 = fe_cnt;
        TX_W = 16'hFFFF;
        CS = 1'b0;
        step(8);
        for (int i = 0; i < 10; i++) sck_cycle(1'b1, b);
        RST = 1'b1;
        step(2);
        chk("f6_rst_busy", BUSY, 1'b0);
        chk("f6_rst_oe", MISO_OE, 1'b0);
        chk("f6_rst_rxw", RX_W, 16'h0000);
        RST = 1'b0;
        busy0 = busy_cnt;
        for (int i = 0; i < 6; i++) sck_cycle(1'b1, b);
        step(4);
        CS = 1'b1;
        step(8);
        chk("f6_rxv_cnt", 16'(rv_cnt - rv0), 16'd0);
        chk("f6_ferr_cnt", 16'(fe_cnt - fe0), 16'd0);
        chk("f6_busy_seen", 16'(busy_cnt - busy0), 16'd0);
        chk("f6_oe_idle", MISO_OE, 1'b0);
        spi_frame(16'h5555, 16, 1'b0, 16'h0, 1'b0, mi, extra);
        chk("f6_rxw", RX_W, 16'h5555);
        chk("f6_rxv_after", 16'(rv_cnt - rv0), 16'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/slave_spi_4post.md
Name: slave_spi_4post

Overview:
SPI responder (slave) for the 16-bit word link driven by the team's SPI master controller.
- Samples the asynchronous CS/SCK/MOSI pins in its own CLK domain.
- Shifts in one 16-bit word per frame and simultaneously shifts out a preloaded 16-bit reply on MISO.
- Sits on the peripheral/target side of the post-machine board link and presents RX_W/RX_VALID to local logic.

Parameters:
SYNC_STAGES, 2, number of flip-flop synchronizer stages on CS, SCK and MOSI (legal 2..3).
WORD_W, 16, frame length in bits; fixed at 16 for this link.

Ports:
CLK  input  1  system clock, single clock domain for all logic.
RST  input  1  reset, synchronous, active-high.
CS  input  1  chip select from master, active-low, asynchronous to CLK.
SCK  input  1  serial clock from master, idle low, asynchronous to CLK.
MOSI  input  1  serial data from master, MSB first.
MISO  output  1  serial data to master, MSB first.
MISO_OE  output  1  high while frame active; board tristate enable for MISO.
TX_W  input  16  reply word, captured at frame start.
RX_W  output  16  last complete word received; holds until next complete frame.
RX_VALID  output  1  one-CLK pulse when RX_W is updated.
BUSY  output  1  high while a frame is in progress.
FRAME_ERR  output  1  one-CLK pulse when CS rises before 16 bits are received.

Behaviour:
- Protocol: SPI mode 0 (CPOL=0, CPHA=0).
  - MOSI sampled on SCK rising edge.
  - MISO changes after SCK falling edge.
  - 16 bits per frame, MSB first.
- Input conditioning: CS, SCK and MOSI each pass through SYNC_STAGES flip-flops.
  - One extra register per synchronized CS/SCK provides previous value for edge detection.
  - Edge detected = synchronized value differs from previous.
- Timing requirement: each SCK high and low phase ≥ SYNC_STAGES+2 CLK periods.
  - Met with master SCK = f_CLK/8 and equal clocks.
- Reset (RST=1 at CLK edge): MISO=0, MISO_OE=0, RX_W=16'h0000, RX_VALID=0, BUSY=0, FRAME_ERR=0.
  - Bit counter=0, shift registers=0, FSM=IDLE.
  - Synchronizers reset to CS=1, SCK=0, MOSI=0.
- FSM states: IDLE, SHIFT, WAIT_END.
  - IDLE:
    - On detected CS falling edge: tx_sh<=TX_W, rx_sh<=0, cnt<=0, BUSY<=1, MISO_OE<=1, go SHIFT.
    - MISO<=TX_W[15] in the same cycle, so bit 15 is valid before the first SCK rise.
  - SHIFT:
    - Detected SCK rise: rx_sh<={rx_sh[14:0], MOSI_sync}, cnt<=cnt+1.
    - If cnt was 15 (16th bit): next cycle RX_W<=completed word and RX_VALID=1 for exactly one cycle; go WAIT_END.
    - Detected SCK fall with cnt<16: tx_sh<={tx_sh[14:0],1'b0}; MISO<=next bit (tx_sh[14]).
  - WAIT_END:
    - Further SCK edges ignored; MISO held at 0.
    - On detected CS rise: go IDLE.
  - Any non-IDLE state, detected CS rise:
    - BUSY<=0, MISO<=0, MISO_OE<=0, go IDLE.
    - If fewer than 16 bits were received: FRAME_ERR=1 for one cycle, RX_W unchanged, no RX_VALID.
- SCK edges while CS synchronized high are ignored.
- CS fall and SCK rise detected in the same cycle: CS fall processed first; the SCK edge is discarded.
- TX_W changes during a frame do not affect the current frame.
- Back-to-back frames: a new CS fall is accepted in the cycle after returning to IDLE.
- RST asserted mid-frame: all outputs return to reset values next edge.
  - Partial frame discarded; no RX_VALID or FRAME_ERR.
  - Frame in progress at reset release is ignored until CS is seen high and then falling.

Test Plan:
1. Reset check: RST high 3 cycles, CS=1 → MISO=0, MISO_OE=0, RX_W=0x0000, RX_VALID=0, BUSY=0, FRAME_ERR=0.
2. Full frame (TX_W=0x3C5A, master sends 0xA5C3, SCK=f_CLK/8) → master captures 0x3C5A, RX_W=0xA5C3, single RX_VALID pulse, BUSY high from CS fall+SYNC_STAGES+1 to CS rise+SYNC_STAGES+1.
3. Aborted frame: first frame 0x1234, then CS raised after 8 SCK cycles of 0xFFFF → FRAME_ERR one pulse, RX_W stays 0x1234, no RX_VALID.
4. Back-to-back frames 0x0001 then 0x8000 with CS high 4 CLK between → two RX_VALID pulses, RX_W=0x0001 then 0x8000; TX_W change mid-frame 1 not seen on MISO until frame 2.
5. Extra clocks: 20 SCK cycles in one frame of 0xBEEF → RX_W=0xBEEF, exactly one RX_VALID, MISO=0 during clocks 17-20.
6. RST mid-frame after 10 bits, release while CS still low, then 6 more SCK → no RX_VALID/FRAME_ERR; next proper frame 0x5555 → RX_W=0x5555.
